// File: rtl/test1_alu.sv
// test1_alu: registered 5-bit signed add/sub/mul/div core with a 9-bit result,
// divide-by-zero and multiply-overflow flags, one-cycle latency, no backpressure.
`timescale 1ns/1ps
module test1_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic [1:0] a_s,
    output logic [8:0] result,
    output logic       out_valid,
    output logic       div_by_zero,
    output logic       ovf
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    op_e               w_op;
    logic [8:0]        w_a_ext;
    logic [8:0]        w_b_ext;
    logic [8:0]        w_sum;
    logic [8:0]        w_diff;
    logic signed [9:0] w_prod;
    logic              w_mul_sat;
    logic [4:0]        w_a_mag;
    logic [4:0]        w_b_mag;
    logic [4:0]        w_q_mag;
    logic [5:0]        w_rem;
    logic              w_q_neg;
    logic              w_b_zero;
    logic [8:0]        w_q_ext;
    logic [8:0]        w_quot;
    logic [8:0]        w_res;
    logic              w_dbz;
    logic              w_ovf;

    logic [8:0]        r_result;
    logic              r_out_valid;
    logic              r_div_by_zero;
    logic              r_ovf;

    assign w_op    = op_e'(a_s);
    assign w_a_ext = {{4{A[4]}}, A};
    assign w_b_ext = {{4{B[4]}}, B};
    assign w_sum   = w_a_ext + w_b_ext;
    assign w_diff  = w_a_ext - w_b_ext;

    // 10-bit signed product holds every 5x5 case; only -16*-16 exceeds +255
    assign w_prod    = $signed({w_a_ext[8], w_a_ext}) * $signed({w_b_ext[8], w_b_ext});
    assign w_mul_sat = (w_prod == 10'sd256);

    assign w_a_mag  = A[4] ? (~A + 5'd1) : A;
    assign w_b_mag  = B[4] ? (~B + 5'd1) : B;
    assign w_q_neg  = A[4] ^ B[4];
    assign w_b_zero = (B == 5'd0);

    // Restoring division on magnitudes gives truncation toward zero once the sign is reapplied
    always_comb begin
        w_rem   = '0;
        w_q_mag = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            w_rem = {w_rem[4:0], w_a_mag[3'(4 - i)]};
            if (w_rem >= {1'b0, w_b_mag}) begin
                w_rem                = w_rem - {1'b0, w_b_mag};
                w_q_mag[3'(4 - i)]   = 1'b1;
            end
        end
    end

    assign w_q_ext = {4'b0000, w_q_mag};
    assign w_quot  = w_q_neg ? (~w_q_ext + 9'd1) : w_q_ext;

    always_comb begin
        w_res = '0;
        w_dbz = 1'b0;
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD: w_res = w_sum;
            OP_SUB: w_res = w_diff;
            OP_MUL: begin
                w_res = w_mul_sat ? 9'd255 : w_prod[8:0];
                w_ovf = w_mul_sat;
            end
            OP_DIV: begin
                if (w_b_zero) begin
                    w_dbz = 1'b1;
                end else begin
                    w_res = w_quot;
                end
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result      <= '0;
            r_out_valid   <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result      <= w_res;
                r_div_by_zero <= w_dbz;
                r_ovf         <= w_ovf;
            end
        end
    end

    assign result      = r_result;
    assign out_valid   = r_out_valid;
    assign div_by_zero = r_div_by_zero;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_test1_alu.sv
// Self-checking bench for test1_alu: directed spec vectors, streaming with gaps,
// async reset mid-stream, and randomized ops against an integer reference model.
`timescale 1ns/1ps
module tb_test1_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] A = '0;
    logic [4:0] B = '0;
    logic [1:0] a_s = '0;
    logic [8:0] result;
    logic       out_valid;
    logic       div_by_zero;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test1_alu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .a_s        (a_s),
        .result     (result),
        .out_valid  (out_valid),
        .div_by_zero(div_by_zero),
        .ovf        (ovf)
    );

    typedef struct {
        int res;
        bit dbz;
        bit ovf;
    } exp_t;

    // Reference: plain integer arithmetic; SV integer division truncates toward zero
    function automatic exp_t model(int op, int a, int b);
        exp_t e;
        e.res = 0;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        case (op)
            0: e.res = a + b;
            1: e.res = a - b;
            2: begin
                e.res = a * b;
                if (e.res > 255) begin
                    e.res = 255;
                    e.ovf = 1'b1;
                end
            end
            default: begin
                if (b == 0) e.dbz = 1'b1;
                else        e.res = a / b;
            end
        endcase
        return e;
    endfunction

    task automatic drive(int op, int a, int b, bit v);
        @(negedge clk);
        in_valid = v;
        a_s      = 2'(op);
        A        = 5'(a);
        B        = 5'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({result, out_valid, div_by_zero, ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_async: got res=%0h ov=%b dbz=%b ovf=%b, want all 0",
                     result, out_valid, div_by_zero, ovf);
        end
        drive(0, 8, 7, 1'b1);
        n_cmp++;
        if ({result, out_valid, div_by_zero, ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_held: got res=%0h ov=%b dbz=%b ovf=%b, want all 0",
                     result, out_valid, div_by_zero, ovf);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_directed();
        int ops[15]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 2};
        int as_[15]  = '{8, -10, 10, -8, -16, 4, -6, -16, 8, -8, -7, 7, 7, -16, -16};
        int bs[15]   = '{7, 5, 3, -4, 15, 3, 2, -16, 4, 2, 2, 0, -2, -1, 15};
        int er[15]   = '{15, -5, 7, -4, -31, 12, -12, 255, 2, -4, -3, 0, -3, 16, -240};
        bit edz[15]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        bit eov[15]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            logic [8:0] w;
            drive(ops[i], as_[i], bs[i], 1'b1);
            w = 9'(er[i]);
            n_cmp++;
            if (result !== w || out_valid !== 1'b1 || div_by_zero !== edz[i] || ovf !== eov[i]) begin
                n_err++;
                $display("FAIL directed_%0d op=%0d A=%0d B=%0d: got res=%0h ov=%b dbz=%b ovf=%b, want res=%0h ov=1 dbz=%b ovf=%b",
                         i, ops[i], as_[i], bs[i], result, out_valid, div_by_zero, ovf, w, edz[i], eov[i]);
            end
            drive(0, 0, 0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0 || result !== w || div_by_zero !== edz[i] || ovf !== eov[i]) begin
                n_err++;
                $display("FAIL directed_idle_%0d: got res=%0h ov=%b dbz=%b ovf=%b, want res=%0h ov=0 dbz=%b ovf=%b",
                         i, result, out_valid, div_by_zero, ovf, w, edz[i], eov[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ops[6] = '{2, 3, 0, 1, 3, 2};
        int as_[6] = '{-16, 7, -16, -16, -16, 5};
        int bs[6]  = '{-16, 0, -16, 15, -1, -3};
        exp_t e;
        logic [8:0] w;
        for (int i = 0; i < 6; i++) begin
            e = model(ops[i], as_[i], bs[i]);
            w = 9'(e.res);
            drive(ops[i], as_[i], bs[i], 1'b1);
            n_cmp++;
            if (result !== w || out_valid !== 1'b1 || div_by_zero !== e.dbz || ovf !== e.ovf) begin
                n_err++;
                $display("FAIL b2b_%0d: got res=%0h ov=%b dbz=%b ovf=%b, want res=%0h ov=1 dbz=%b ovf=%b",
                         i, result, out_valid, div_by_zero, ovf, w, e.dbz, e.ovf);
            end
        end
        drive(1, 3, 3, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || result !== w || ovf !== e.ovf || div_by_zero !== e.dbz) begin
            n_err++;
            $display("FAIL b2b_gap: got res=%0h ov=%b dbz=%b ovf=%b, want res=%0h ov=0 dbz=%b ovf=%b",
                     result, out_valid, div_by_zero, ovf, w, e.dbz, e.ovf);
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic [8:0] held_res = result;
        bit         held_dbz = div_by_zero;
        bit         held_ovf = ovf;
        for (int n = 0; n < 300; n++) begin
            int op = int'($urandom_range(0, 3));
            int a  = int'($urandom_range(0, 31)) - 16;
            int b  = int'($urandom_range(0, 31)) - 16;
            bit v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) b = 0;
            if ($urandom_range(0, 19) == 0) begin a = -16; b = -16; end
            drive(op, a, b, v);
            if (v) begin
                e        = model(op, a, b);
                held_res = 9'(e.res);
                held_dbz = e.dbz;
                held_ovf = e.ovf;
            end
            n_cmp++;
            if (result !== held_res || out_valid !== v || div_by_zero !== held_dbz || ovf !== held_ovf) begin
                n_err++;
                $display("FAIL random_%0d op=%0d A=%0d B=%0d v=%b: got res=%0h ov=%b dbz=%b ovf=%b, want res=%0h ov=%b dbz=%b ovf=%b",
                         n, op, a, b, v, result, out_valid, div_by_zero, ovf, held_res, v, held_dbz, held_ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(2, -16, -16, 1'b1);
        drive(3, 7, 0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({result, out_valid, div_by_zero, ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL midstream_rst: got res=%0h ov=%b dbz=%b ovf=%b, want all 0",
                     result, out_valid, div_by_zero, ovf);
        end
        drive(0, 8, 7, 1'b1);
        n_cmp++;
        if ({result, out_valid, div_by_zero, ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL rst_discard: got res=%0h ov=%b dbz=%b ovf=%b, want all 0",
                     result, out_valid, div_by_zero, ovf);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        a_s      = 2'b10;
        A        = 5'd4;
        B        = 5'd3;
        @(posedge clk);
        #1;
        n_cmp++;
        if (result !== 9'd12 || out_valid !== 1'b1 || div_by_zero !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst_mul: got res=%0h ov=%b dbz=%b ovf=%b, want res=00c ov=1 dbz=0 ovf=0",
                     result, out_valid, div_by_zero, ovf);
        end
        drive(0, 0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
